axis_uart_reg_responder: RTL and testbench

//  Host-side command responder between axis_uart_rx_wrapper (o_* stream in) and

---
 rtl/axis_uart_reg_responder.sv | 166 ++++++++++++++++
 tb/tb_axis_uart_reg_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_reg_responder.sv
// Byte-command responder: parses 'R' addr / 'W' addr data frames from a UART RX stream,
// accesses a four-entry board register file and returns one reply byte per command.
module axis_uart_reg_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 80000,
  parameter int unsigned TIMEOUT_W      = 17,
  parameter logic [7:0]  LED_RESET      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tvalid,
  output logic       i_tready,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       o_tready,
  input  logic [7:0] dip_switch,
  input  logic [3:0] push_button,
  output logic [7:0] leds,
  output logic [7:0] err_count
);

  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;
  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TmoOne  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StGetAddr, StGetData, StExec, StResp} state_e;

  state_e state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic                 nak_q, nak_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [7:0]           leds_q, leds_d;
  logic [7:0]           scratch_q, scratch_d;
  logic [7:0]           err_q, err_d;
  logic [7:0]           odata_q, odata_d;
  logic                 ovalid_q, ovalid_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 err_inc;

  assign accept    = i_tvalid & ready_q;
  assign i_tready  = ready_q;
  assign o_tdata   = odata_q;
  assign o_tvalid  = ovalid_q;
  assign leds      = leds_q;
  assign err_count = err_q;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    nak_d      = nak_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = '0;
    leds_d     = leds_q;
    scratch_d  = scratch_q;
    odata_d    = odata_q;
    ovalid_d   = ovalid_q;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (i_tdata == CmdRead || i_tdata == CmdWrite) begin
            is_write_d = (i_tdata == CmdWrite);
            nak_d      = 1'b0;
            state_d    = StGetAddr;
          end else begin
            // Unknown command is answered at once and consumes no further bytes.
            nak_d   = 1'b1;
            state_d = StExec;
          end
        end
      end
      StGetAddr: begin
        if (accept) begin
          addr_d  = i_tdata;
          state_d = is_write_q ? StGetData : StExec;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoOne;
        end
      end
      StGetData: begin
        if (accept) begin
          data_d  = i_tdata;
          state_d = StExec;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoOne;
        end
      end
      StExec: begin
        state_d  = StResp;
        ovalid_d = 1'b1;
        // Addresses 2 and 3 are read-only inputs.
        if (nak_q || addr_q > 8'h03 || (is_write_q && addr_q[1])) begin
          odata_d = RespNak;
          err_inc = 1'b1;
        end else if (is_write_q) begin
          odata_d = RespAck;
          if (addr_q[0]) scratch_d = data_q;
          else           leds_d    = data_q;
        end else begin
          unique case (addr_q[1:0])
            2'd0:    odata_d = leds_q;
            2'd1:    odata_d = scratch_q;
            2'd2:    odata_d = dip_switch;
            default: odata_d = {4'h0, ~push_button};
          endcase
        end
      end
      StResp: begin
        if (o_tready) begin
          ovalid_d = 1'b0;
          odata_d  = 8'h00;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    err_d   = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    ready_d = (state_d == StIdle) || (state_d == StGetAddr) || (state_d == StGetData);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      nak_q      <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      tmo_q      <= '0;
      leds_q     <= LED_RESET;
      scratch_q  <= 8'h00;
      err_q      <= 8'h00;
      odata_q    <= 8'h00;
      ovalid_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      nak_q      <= nak_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      leds_q     <= leds_d;
      scratch_q  <= scratch_d;
      err_q      <= err_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_axis_uart_reg_responder.sv
// Bench for axis_uart_reg_responder: frame-level reference model feeding a reply queue,
// a per-cycle output checker and directed command sequences with literal expectations.
module tb_axis_uart_reg_responder;

  localparam int unsigned Tmo = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_tdata;
  logic       i_tvalid;
  logic       i_tready;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       o_tready;
  logic [7:0] dip_switch;
  logic [3:0] push_button;
  logic [7:0] leds;
  logic [7:0] err_count;

  axis_uart_reg_responder #(
    .TIMEOUT_CYCLES(Tmo),
    .TIMEOUT_W     (6),
    .LED_RESET     (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tdata    (i_tdata),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .dip_switch (dip_switch),
    .push_button(push_button),
    .leds       (leds),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] leds;
    logic [7:0] err;
  } exp_t;

  exp_t       exp_q[$];
  int         phase;
  logic [7:0] m_cmd, m_addr, m_leds, m_scratch, m_err;
  logic [7:0] last_reply;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one call per accepted byte, replies queued in order.
  task automatic model_reset();
    phase = 0; m_cmd = 0; m_addr = 0;
    m_leds = 8'h00; m_scratch = 8'h00; m_err = 8'h00;
    exp_q.delete();
  endtask

  task automatic err_bump();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic push_reply(input logic [7:0] d);
    exp_t e;
    if (d == 8'h15) err_bump();
    e.data = d; e.leds = m_leds; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] rd;
    if (phase == 0) begin
      if (b == "R" || b == "W") begin m_cmd = b; phase = 1; end
      else push_reply(8'h15);
    end else if (phase == 1) begin
      m_addr = b;
      if (m_cmd == "W") phase = 2;
      else begin
        phase = 0;
        case (m_addr)
          8'd0: rd = m_leds;
          8'd1: rd = m_scratch;
          8'd2: rd = dip_switch;
          8'd3: rd = {4'h0, ~push_button};
          default: rd = 8'h15;
        endcase
        push_reply(rd);
      end
    end else begin
      phase = 0;
      if (m_addr == 8'd0)      begin m_leds = b;    push_reply(8'h06); end
      else if (m_addr == 8'd1) begin m_scratch = b; push_reply(8'h06); end
      else push_reply(8'h15);
    end
  endtask

  // Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 0;
    i_tdata  = b;
    i_tvalid = 1'b1;
    while (!done && n < 200) begin
      if (i_tready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (done) model_byte(b);
    else begin
      vectors++; miscompares++;
      $display("FAIL send_byte: byte %02h not accepted, i_tready %0b, expected 1", b, i_tready);
    end
    @(negedge clk);
    i_tvalid = 1'b0;
  endtask

  task automatic wait_replies();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reply_wait: %0d replies outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs();
    check8("rst_i_tready", {7'b0, i_tready}, 8'h00);
    check8("rst_o_tvalid", {7'b0, o_tvalid}, 8'h00);
    check8("rst_o_tdata", o_tdata, 8'h00);
    check8("rst_leds", leds, 8'h00);
    check8("rst_err_count", err_count, 8'h00);
  endtask

  // Output checker, sampled 1 time unit after each falling edge.
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check8("hold_valid", {7'b0, o_tvalid}, 8'h01);
        check8("hold_data", o_tdata, prev_data);
      end
      if (o_tvalid) begin
        check8("ready_during_reply", {7'b0, i_tready}, 8'h00);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_reply: o_tdata %02h, expected no o_tvalid", o_tdata);
        end else if (o_tready) begin
          exp_t e;
          e = exp_q.pop_front();
          check8("reply_data", o_tdata, e.data);
          check8("reply_leds", leds, e.leds);
          check8("reply_err", err_count, e.err);
          last_reply = o_tdata;
        end
      end
      prev_valid = o_tvalid;
      prev_ready = o_tready;
      prev_data  = o_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_tvalid = 1'b0; i_tdata = 8'h00; o_tready = 1'b1;
    dip_switch = 8'h00; push_button = 4'hF; last_reply = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check8("ready_after_reset", {7'b0, i_tready}, 8'h01);

    // Writes to LEDs and scratch.
    send_byte("W"); send_byte(8'h00); send_byte(8'hA5);
    check8("leds_before_exec", leds, 8'h00);
    @(negedge clk);
    check8("leds_after_exec", leds, 8'hA5);
    wait_replies();
    check8("ack_literal", last_reply, 8'h06);
    send_byte("W"); send_byte(8'h01); send_byte(8'h5A);
    wait_replies();

    // Read-only inputs.
    dip_switch = 8'h3C;
    send_byte("R"); send_byte(8'h02);
    wait_replies();
    check8("dip_literal", last_reply, 8'h3C);
    push_button = 4'b1110;
    send_byte("R"); send_byte(8'h03);
    wait_replies();
    check8("button_literal", last_reply, 8'h01);

    // NAK paths.
    send_byte("W"); send_byte(8'h02); send_byte(8'h11);
    wait_replies();
    check8("nak_ro_literal", last_reply, 8'h15);
    check8("err_after_ro_write", err_count, 8'h01);
    send_byte(8'h41);
    wait_replies();
    check8("nak_cmd_literal", last_reply, 8'h15);
    check8("err_after_bad_cmd", err_count, 8'h02);
    send_byte("R"); send_byte(8'h07);
    wait_replies();
    check8("nak_addr_literal", last_reply, 8'h15);
    check8("leds_unchanged", leds, 8'hA5);

    // Timeout fires on the TIMEOUT_CYCLES-th idle edge, not one earlier.
    send_byte("R");
    repeat (Tmo - 1) @(negedge clk);
    check8("err_before_timeout", err_count, 8'h03);
    @(negedge clk);
    check8("err_after_timeout", err_count, 8'h04);
    check8("ready_after_timeout", {7'b0, i_tready}, 8'h01);
    phase = 0; err_bump();
    send_byte("R"); send_byte(8'h01);
    wait_replies();
    check8("scratch_literal", last_reply, 8'h5A);

    // Back-pressure on the reply while the next command is offered.
    send_byte("W"); send_byte(8'h00); send_byte(8'hC3);
    o_tready = 1'b0;
    fork
      begin
        repeat (20) @(negedge clk);
        o_tready = 1'b1;
      end
      begin
        send_byte("R"); send_byte(8'h00);
      end
    join
    wait_replies();
    check8("bp_read_literal", last_reply, 8'hC3);

    // Reset in the middle of a write frame.
    send_byte("W"); send_byte(8'h01);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    send_byte("R"); send_byte(8'h01);
    wait_replies();
    check8("scratch_after_reset", last_reply, 8'h00);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
